// File: rtl/multi_pwm_ctrl.sv
// Multi-channel closed-loop wheel-angle controller: one angle FSM and PWM handshake per channel.
// Optional stall detection is built when MULTI_PWM_STALL_DET_EN is defined.
module multi_pwm_ch #(
    parameter int ANGLE_W       = 12,
    parameter int RATIO_W       = 8,
    parameter int TOL           = 4,
    parameter int GAIN_SHIFT    = 2,
    parameter int MIN_RATIO     = 20,
    parameter int MAX_RATIO     = 200,
    parameter int STALL_SAMPLES = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [ANGLE_W-1:0] tgt,
    input  logic               update,
    input  logic               abort,
    input  logic               cap,
    input  logic [ANGLE_W-1:0] sample,
    input  logic               pwm_done,
    output logic               done,
    output logic [ANGLE_W-1:0] cur,
    output logic               pwm_update,
    output logic               pwm_enable,
    output logic [RATIO_W-1:0] ratio,
    output logic               dir,
    output logic               stall_fail
);
    typedef enum logic [1:0] {IDLE, EVAL, UPDATE, WAIT} state_t;
    localparam logic [ANGLE_W-1:0] HALF = ANGLE_W'(1) << (ANGLE_W - 1);

    state_t             state;
    logic [ANGLE_W-1:0] target, err, err_neg;
    logic               sample_new, pend, dir_c, stall_hit;
    logic [31:0]        mag, shifted, ratio_c;

    if (STALL_SAMPLES < 1) begin : g_bad_stall
        $error("STALL_SAMPLES must be at least 1");
    end

    // Exact half turn resolves to the positive direction.
    always_comb begin
        err     = target - cur;
        err_neg = -err;
        dir_c   = (err <= HALF);
        mag     = dir_c ? 32'(err) : 32'(err_neg);
        shifted = mag >> GAIN_SHIFT;
        ratio_c = shifted;
        if (shifted < 32'(MIN_RATIO)) ratio_c = 32'(MIN_RATIO);
        if (shifted > 32'(MAX_RATIO)) ratio_c = 32'(MAX_RATIO);
    end

`ifdef MULTI_PWM_STALL_DET_EN
    localparam int SC_W = $clog2(STALL_SAMPLES + 1);
    logic [SC_W-1:0] scnt;
    logic            same;

    assign same      = cap && (sample == cur) && (state == UPDATE || state == WAIT);
    assign stall_hit = same && !update && !abort && (32'(scnt) == 32'(STALL_SAMPLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scnt       <= '0;
            stall_fail <= 1'b0;
        end else begin
            if (update || (cap && sample != cur)) scnt <= '0;
            else if (same)                        scnt <= scnt + 1'b1;
            if (update)         stall_fail <= 1'b0;
            else if (stall_hit) stall_fail <= 1'b1;
        end
    end
`else
    assign stall_hit  = 1'b0;
    assign stall_fail = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            target     <= '0;
            cur        <= '0;
            sample_new <= 1'b0;
            pend       <= 1'b0;
            done       <= 1'b0;
            pwm_update <= 1'b0;
            pwm_enable <= 1'b0;
            ratio      <= '0;
            dir        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cap) cur <= sample;
            if (cap)                sample_new <= 1'b1;
            else if (state == EVAL) sample_new <= 1'b0;

            if (abort || stall_hit) begin
                state      <= IDLE;
                pwm_enable <= 1'b0;
                pwm_update <= 1'b0;
                ratio      <= '0;
                pend       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (update) begin
                        target <= tgt;
                        state  <= EVAL;
                    end
                    EVAL: begin
                        if (update) begin
                            target <= tgt;
                        end else if (mag <= 32'(TOL)) begin
                            done       <= 1'b1;
                            pwm_enable <= 1'b0;
                            ratio      <= '0;
                            state      <= IDLE;
                        end else begin
                            ratio      <= ratio_c[RATIO_W-1:0];
                            dir        <= dir_c;
                            pwm_enable <= 1'b1;
                            pwm_update <= 1'b1;
                            state      <= UPDATE;
                        end
                    end
                    // A retarget during the handshake is remembered and evaluated after the ack.
                    UPDATE: begin
                        if (update) target <= tgt;
                        if (pwm_done) begin
                            pwm_update <= 1'b0;
                            pend       <= 1'b0;
                            state      <= (pend || update) ? EVAL : WAIT;
                        end else if (update) begin
                            pend <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (update) target <= tgt;
                        if (update || sample_new || cap) state <= EVAL;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

module multi_pwm_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int ANGLE_W       = 12,
    parameter int RATIO_W       = 8,
    parameter int TOL           = 4,
    parameter int GAIN_SHIFT    = 2,
    parameter int MIN_RATIO     = 20,
    parameter int MAX_RATIO     = 200,
    parameter int STALL_SAMPLES = 8,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_CH*ANGLE_W-1:0]  target_angle,
    input  logic [NUM_CH-1:0]          angle_update,
    input  logic [NUM_CH-1:0]          abort_angle,
    output logic [NUM_CH-1:0]          angle_done,
    output logic [NUM_CH*ANGLE_W-1:0]  current_angle,
    input  logic                       enc_valid,
    input  logic [CH_W-1:0]            enc_ch,
    input  logic [ANGLE_W-1:0]         enc_angle,
    output logic [NUM_CH-1:0]          pwm_update,
    input  logic [NUM_CH-1:0]          pwm_done,
    output logic [NUM_CH-1:0]          pwm_enable,
    output logic [NUM_CH*RATIO_W-1:0]  pwm_ratio,
    output logic [NUM_CH-1:0]          pwm_direction,
    output logic [NUM_CH-1:0]          stall_fail
);
    // Tags with no matching channel simply match no instance and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] ID = CH_W'(i);
        multi_pwm_ch #(
            .ANGLE_W(ANGLE_W), .RATIO_W(RATIO_W), .TOL(TOL), .GAIN_SHIFT(GAIN_SHIFT),
            .MIN_RATIO(MIN_RATIO), .MAX_RATIO(MAX_RATIO), .STALL_SAMPLES(STALL_SAMPLES)
        ) u_ch (
            .clock      (clock),
            .reset_n    (reset_n),
            .tgt        (target_angle[i*ANGLE_W +: ANGLE_W]),
            .update     (angle_update[i]),
            .abort      (abort_angle[i]),
            .cap        (enc_valid && (enc_ch == ID)),
            .sample     (enc_angle),
            .pwm_done   (pwm_done[i]),
            .done       (angle_done[i]),
            .cur        (current_angle[i*ANGLE_W +: ANGLE_W]),
            .pwm_update (pwm_update[i]),
            .pwm_enable (pwm_enable[i]),
            .ratio      (pwm_ratio[i*RATIO_W +: RATIO_W]),
            .dir        (pwm_direction[i]),
            .stall_fail (stall_fail[i])
        );
    end
endmodule
